// File: rtl/pio_pkg.sv
// pio_pkg: register map and pulse-state encoding shared by the PIO blocks
package pio_pkg;
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_PWIDTH = 3'd1;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;
   localparam logic [2:0] ADDR_PULSE  = 3'd6;
   localparam int STATUS_BUSY_BIT = 0;
   typedef enum logic {IDLE, PULSE} pulse_state_t;
endpackage

// File: rtl/pio_pulse_timer.sv
// pio_pulse_timer: one-shot mask held for max(width,1) clocks, re-triggerable
module pio_pulse_timer
   import pio_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int PULSE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               trigger,
   input  logic [DATA_W-1:0]  trig_mask,
   input  logic [PULSE_W-1:0] width,
   output logic [DATA_W-1:0]  mask,
   output logic               busy
);
   pulse_state_t state;
   logic [PULSE_W-1:0] cnt;
   logic [PULSE_W-1:0] load;
   assign load = (width == '0) ? PULSE_W'(1) : width;
   // mask is zero whenever idle, so OR-ing covers both first trigger and re-trigger
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         mask  <= '0;
         busy  <= 1'b0;
      end else if (trigger) begin
         state <= PULSE;
         cnt   <= load;
         mask  <= mask | trig_mask;
         busy  <= 1'b1;
      end else if (state == PULSE) begin
         cnt <= cnt - PULSE_W'(1);
         if (cnt == PULSE_W'(1)) begin
            state <= IDLE;
            mask  <= '0;
            busy  <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/pio_out_pulse_32.sv
// pio_out_pulse_32: Avalon-MM output PIO with set/clear and timed pulse registers
module pio_out_pulse_32
   import pio_pkg::*;
#(
   parameter int                DATA_W      = 32,
   parameter int                PULSE_W     = 16,
   parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_port,
   output logic              busy
);
   logic               wr;
   logic [DATA_W-1:0]  wd;
   logic [DATA_W-1:0]  data_reg;
   logic [DATA_W-1:0]  mask;
   logic [PULSE_W-1:0] pulse_width;
   logic [31:0]        rd_mux;
   assign wr = chipselect && !write_n;
   assign wd = writedata[DATA_W-1:0];
   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg    <= RESET_VALUE;
         pulse_width <= PULSE_W'(1);
         readdata    <= '0;
      end else begin
         readdata <= rd_mux;
         if (wr) begin
            data_reg <= address == ADDR_DATA   ? wd :
                        address == ADDR_OUTSET ? data_reg | wd :
                        address == ADDR_OUTCLR ? data_reg & ~wd : data_reg;
            if (address == ADDR_PWIDTH)
               pulse_width <= writedata[PULSE_W-1:0];
         end
      end
   end
   always_comb begin
      rd_mux = address == ADDR_DATA   ? 32'(data_reg) :
               address == ADDR_PWIDTH ? 32'(pulse_width) :
               address == ADDR_STATUS ? 32'(busy) << STATUS_BUSY_BIT : '0;
   end
   pio_pulse_timer #(.DATA_W(DATA_W), .PULSE_W(PULSE_W)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .trigger   (wr && address == ADDR_PULSE),
      .trig_mask (wd),
      .width     (pulse_width),
      .mask      (mask),
      .busy      (busy)
   );
   // both operands are registers, so out_port has no path from the bus inputs
   assign out_port = data_reg | mask;
endmodule
